fc_event_queue: RTL

//  Collects single-cycle event pulses from SoC peripherals (uDMA, timers, GPIO, HWPE) and queues them for the

---
 rtl/fc_event_queue.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fc_event_queue.sv
// fc_event_queue: latches single-cycle event pulses per source, picks one pending source per
// cycle round-robin and queues its ID for the fabric-controller event FIFO interface.
// Optional build macro FC_EVT_DROP_CNT_EN adds a saturating counter of events lost to overrun;
// without it drop_cnt_o is tied to zero.
module fc_event_queue #(
    parameter int unsigned NB_EVT       = 32,
    parameter int unsigned EVT_ID_WIDTH = 8,
    parameter int unsigned ID_BASE      = 0,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NB_EVT-1:0]             events_i,
    output logic                          evt_valid_o,
    output logic [EVT_ID_WIDTH-1:0]       evt_data_o,
    input  logic                          evt_fulln_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic [7:0]                    drop_cnt_o
);

    localparam int unsigned IDX_W = $clog2(NB_EVT);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned LW    = AW + 1;

    logic [NB_EVT-1:0]       pending_q;
    logic [NB_EVT-1:0]       pending_d;
    logic [NB_EVT-1:0]       grant;
    logic [IDX_W-1:0]        rr_ptr_q;
    logic [IDX_W-1:0]        rr_ptr_d;
    logic [IDX_W-1:0]        gnt_idx;
    logic [IDX_W-1:0]        cand;
    logic                    gnt_valid;

    logic [EVT_ID_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr_q;
    logic [AW-1:0]           rd_ptr_q;
    logic [LW-1:0]           level_q;
    logic [LW-1:0]           level_d;
    logic                    push;
    logic                    pop;

    // Round-robin search over registered pending, starting at rr_ptr; blocked when the
    // registered level is full (a same-cycle pop does not make room).
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        if ((|pending_q) && (level_q < LW'(FIFO_DEPTH))) begin
            for (int unsigned i = 0; i < NB_EVT; i++) begin
                cand = IDX_W'((32'(rr_ptr_q) + i) % NB_EVT);
                if (!gnt_valid && pending_q[cand]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = cand;
                end
            end
        end
    end

    // Grant decode, pending next state and round-robin pointer advance.
    always_comb begin
        grant     = gnt_valid ? (NB_EVT'(1) << gnt_idx) : '0;
        pending_d = (pending_q & ~grant) | events_i;
        rr_ptr_d  = rr_ptr_q;
        if (gnt_valid) begin
            rr_ptr_d = (gnt_idx == IDX_W'(NB_EVT - 1)) ? '0 : gnt_idx + IDX_W'(1);
        end
    end

    // FIFO handshake and occupancy next state.
    always_comb begin
        push    = gnt_valid;
        pop     = evt_valid_o & evt_fulln_i;
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Pending latches, arbiter pointer and FIFO control; reset discards everything queued.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= '0;
            rr_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
        end else begin
            pending_q <= pending_d;
            rr_ptr_q  <= rr_ptr_d;
            level_q   <= level_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    // Queue storage; contents are only observable while level is non-zero, so no reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push) begin
            mem_q[wr_ptr_q] <= EVT_ID_WIDTH'(ID_BASE) + EVT_ID_WIDTH'(gnt_idx);
        end
    end

    // Head of queue presented to the consumer; data forced to zero when empty.
    always_comb begin
        evt_valid_o  = (level_q != '0);
        evt_data_o   = evt_valid_o ? mem_q[rd_ptr_q] : '0;
        fifo_level_o = level_q;
    end

`ifdef FC_EVT_DROP_CNT_EN
    logic [NB_EVT-1:0] overrun;
    logic [7:0]        drop_q;
    logic [7:0]        drop_d;
    int unsigned       drop_sum;

    // Count every source whose new pulse hits a still-pending, ungranted latch; saturate at 255.
    always_comb begin
        overrun  = events_i & pending_q & ~grant;
        drop_sum = 32'(drop_q);
        for (int unsigned i = 0; i < NB_EVT; i++) begin
            drop_sum = drop_sum + 32'(overrun[i]);
        end
        drop_d = (drop_sum > 32'd255) ? 8'hFF : 8'(drop_sum);
    end

    // Overrun counter register, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) drop_q <= '0;
        else       drop_q <= drop_d;
    end

    assign drop_cnt_o = drop_q;
`else
    assign drop_cnt_o = 8'h00;
`endif

endmodule
